// File: rtl/piso_tx8.sv
// Parallel-in, serial-out transmitter: accepts a word on a valid/ready handshake
// and shifts it out one bit per clock, with one idle bit between words.
module piso_tx8 #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          LSB_FIRST = 1'b1,
    parameter logic        IDLE_LVL  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] PI,
    input  logic             valid,
    output logic             ready,
    output logic             serOut,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    if (WIDTH < 2 || WIDTH > 16) begin : g_width_check
        $error("piso_tx8: WIDTH must be in 2..16");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;

    assign ready = (state == IDLE);

    // sreg holds the untransmitted tail; the bit next to the output end is sent next
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            sreg   <= '0;
            serOut <= IDLE_LVL;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid) begin
                        state  <= SHIFT;
                        sreg   <= PI;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        serOut <= LSB_FIRST ? PI[0] : PI[WIDTH-1];
                    end
                end
                SHIFT: begin
                    if (cnt == LAST) begin
                        state  <= IDLE;
                        cnt    <= '0;
                        serOut <= IDLE_LVL;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                        if (LSB_FIRST) begin
                            sreg   <= sreg >> 1;
                            serOut <= sreg[1];
                        end else begin
                            sreg   <= sreg << 1;
                            serOut <= sreg[WIDTH-2];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_piso_tx8.sv
// Scoreboard bench for piso_tx8: three instances (8-bit LSB-first, 8-bit MSB-first,
// 4-bit with idle level 1), each with a same-clock receiver and a bit/word monitor.
module tb_piso_tx8;

    typedef struct packed {
        logic b;
        logic last;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic       rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
    logic       valid_a = 1'b0, valid_b = 1'b0, valid_c = 1'b0;
    logic [7:0] pi_a = '0, pi_b = '0;
    logic [3:0] pi_c = '0;
    logic       ready_a, ser_a, busy_a, done_a;
    logic       ready_b, ser_b, busy_b, done_b;
    logic       ready_c, ser_c, busy_c, done_c;
    logic [7:0] rx_a = '0, rx_b = '0;
    logic [3:0] rx_c = '0;

    exp_t        qa[$], qb[$], qc[$];
    logic [15:0] wa[$], wb[$], wc[$];
    logic        dn_a = 1'b0, dn_b = 1'b0, dn_c = 1'b0;

    piso_tx8 #(.WIDTH(8), .LSB_FIRST(1'b1), .IDLE_LVL(1'b0)) u_a (
        .clk(clk), .rst(rst_a), .PI(pi_a), .valid(valid_a),
        .ready(ready_a), .serOut(ser_a), .busy(busy_a), .done(done_a)
    );
    piso_tx8 #(.WIDTH(8), .LSB_FIRST(1'b0), .IDLE_LVL(1'b0)) u_b (
        .clk(clk), .rst(rst_b), .PI(pi_b), .valid(valid_b),
        .ready(ready_b), .serOut(ser_b), .busy(busy_b), .done(done_b)
    );
    piso_tx8 #(.WIDTH(4), .LSB_FIRST(1'b1), .IDLE_LVL(1'b1)) u_c (
        .clk(clk), .rst(rst_c), .PI(pi_c), .valid(valid_c),
        .ready(ready_c), .serOut(ser_c), .busy(busy_c), .done(done_c)
    );

    // Receivers sharing clk: first bit sent ends up in the word position it came from
    always @(posedge clk) begin
        rx_a <= {ser_a, rx_a[7:1]};
        rx_b <= {rx_b[6:0], ser_b};
        rx_c <= {ser_c, rx_c[3:1]};
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_a(input logic [7:0] w);
        for (int i = 0; i < 8; i++) begin
            exp_t e;
            e.b = w[i];
            e.last = (i == 7);
            qa.push_back(e);
        end
        wa.push_back(16'(w));
    endtask

    task automatic push_b(input logic [7:0] w);
        for (int i = 0; i < 8; i++) begin
            exp_t e;
            e.b = w[7-i];
            e.last = (i == 7);
            qb.push_back(e);
        end
        wb.push_back(16'(w));
    endtask

    task automatic push_c(input logic [3:0] w);
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            e.b = w[i];
            e.last = (i == 3);
            qc.push_back(e);
        end
        wc.push_back(16'(w));
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst_a) begin
            qa.delete(); wa.delete(); dn_a = 1'b0;
            chk("a_rst_busy", 16'(busy_a), 16'(0));
            chk("a_rst_done", 16'(done_a), 16'(0));
            chk("a_rst_ser", 16'(ser_a), 16'(0));
            chk("a_rst_ready", 16'(ready_a), 16'(1));
        end else begin
            chk("a_done", 16'(done_a), 16'(dn_a));
            if (dn_a) begin
                chk("a_word_expected", 16'(wa.size() != 0), 16'(1));
                if (wa.size() != 0) chk("a_rx_word", 16'(rx_a), wa.pop_front());
            end
            dn_a = 1'b0;
            if (busy_a) begin
                chk("a_ready_busy", 16'(ready_a), 16'(0));
                chk("a_bit_expected", 16'(qa.size() != 0), 16'(1));
                if (qa.size() != 0) begin
                    e = qa.pop_front();
                    chk("a_bit", 16'(ser_a), 16'(e.b));
                    dn_a = e.last;
                end
            end else begin
                chk("a_idle_ser", 16'(ser_a), 16'(0));
                chk("a_idle_ready", 16'(ready_a), 16'(1));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst_b) begin
            qb.delete(); wb.delete(); dn_b = 1'b0;
            chk("b_rst_busy", 16'(busy_b), 16'(0));
            chk("b_rst_done", 16'(done_b), 16'(0));
            chk("b_rst_ser", 16'(ser_b), 16'(0));
            chk("b_rst_ready", 16'(ready_b), 16'(1));
        end else begin
            chk("b_done", 16'(done_b), 16'(dn_b));
            if (dn_b) begin
                chk("b_word_expected", 16'(wb.size() != 0), 16'(1));
                if (wb.size() != 0) chk("b_rx_word", 16'(rx_b), wb.pop_front());
            end
            dn_b = 1'b0;
            if (busy_b) begin
                chk("b_ready_busy", 16'(ready_b), 16'(0));
                chk("b_bit_expected", 16'(qb.size() != 0), 16'(1));
                if (qb.size() != 0) begin
                    e = qb.pop_front();
                    chk("b_bit", 16'(ser_b), 16'(e.b));
                    dn_b = e.last;
                end
            end else begin
                chk("b_idle_ser", 16'(ser_b), 16'(0));
                chk("b_idle_ready", 16'(ready_b), 16'(1));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst_c) begin
            qc.delete(); wc.delete(); dn_c = 1'b0;
            chk("c_rst_busy", 16'(busy_c), 16'(0));
            chk("c_rst_done", 16'(done_c), 16'(0));
            chk("c_rst_ser", 16'(ser_c), 16'(1));
            chk("c_rst_ready", 16'(ready_c), 16'(1));
        end else begin
            chk("c_done", 16'(done_c), 16'(dn_c));
            if (dn_c) begin
                chk("c_word_expected", 16'(wc.size() != 0), 16'(1));
                if (wc.size() != 0) chk("c_rx_word", 16'(rx_c), wc.pop_front());
            end
            dn_c = 1'b0;
            if (busy_c) begin
                chk("c_ready_busy", 16'(ready_c), 16'(0));
                chk("c_bit_expected", 16'(qc.size() != 0), 16'(1));
                if (qc.size() != 0) begin
                    e = qc.pop_front();
                    chk("c_bit", 16'(ser_c), 16'(e.b));
                    dn_c = e.last;
                end
            end else begin
                chk("c_idle_ser", 16'(ser_c), 16'(1));
                chk("c_idle_ready", 16'(ready_c), 16'(1));
            end
        end
    end

    initial begin
        // Reset for 3 clocks, then 10 idle clocks
        #1 rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        repeat (10) @(posedge clk);

        // Single LSB-first word 8'hA5
        #1 pi_a = 8'hA5; valid_a = 1'b1; push_a(8'hA5);
        @(posedge clk);
        #1 valid_a = 1'b0;
        repeat (12) @(posedge clk);

        // MSB-first back-to-back 8'h81, 8'h3C with valid held high
        #1 pi_b = 8'h81; valid_b = 1'b1; push_b(8'h81); push_b(8'h3C);
        @(posedge clk);
        #1 pi_b = 8'h3C;
        repeat (9) @(posedge clk);
        #1 valid_b = 1'b0;
        repeat (12) @(posedge clk);

        // Inputs ignored during SHIFT
        #1 pi_a = 8'hF0; valid_a = 1'b1; push_a(8'hF0);
        @(posedge clk);
        #1 pi_a = 8'h0F; valid_a = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1 valid_a = ~valid_a;
        end
        valid_a = 1'b0;
        repeat (10) @(posedge clk);

        // Asynchronous reset in the middle of 8'hFF, then 8'h55
        #1 pi_a = 8'hFF; valid_a = 1'b1; push_a(8'hFF);
        @(posedge clk);
        #1 valid_a = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_a = 1'b0;
        #1;
        chk("a_async_busy", 16'(busy_a), 16'(0));
        chk("a_async_ser", 16'(ser_a), 16'(0));
        chk("a_async_done", 16'(done_a), 16'(0));
        repeat (2) @(posedge clk);
        #1 rst_a = 1'b1; pi_a = 8'h55; valid_a = 1'b1; push_a(8'h55);
        @(posedge clk);
        #1 valid_a = 1'b0;
        repeat (12) @(posedge clk);

        // 4-bit word with idle level 1
        #1 pi_c = 4'h6; valid_c = 1'b1; push_c(4'h6);
        @(posedge clk);
        #1 valid_c = 1'b0;
        repeat (8) @(posedge clk);

        #1;
        chk("a_queue_drained", 16'(qa.size() + wa.size()), 16'(0));
        chk("b_queue_drained", 16'(qb.size() + wb.size()), 16'(0));
        chk("c_queue_drained", 16'(qc.size() + wc.size()), 16'(0));
        chk("done_pending", 16'({dn_a, dn_b, dn_c}), 16'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
